piso_arb_ctrl: RTL and testbench



---
 rtl/piso_arb_ctrl.sv | 120 ++++++++++++
 tb/tb_piso_arb_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin serializer: grants one word at a time, shifts it out
// LSB-first with start/last strobes, then holds off for GAP idle cycles.
module piso_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy,
    output logic             last_src
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  sr_reg, sr_next;
    logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
    logic              gnt0_next, gnt1_next, src_next, sel;
    logic              valid_next, start_next, last_next, busy_next;

    always_comb begin
        state_next   = state_reg;
        sr_next      = sr_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        gnt0_next    = 1'b0;
        gnt1_next    = 1'b0;
        src_next     = last_src;
        sel          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req0 | req1) begin
                    // On contention the source that did not win last time goes next.
                    sel          = (req0 & req1) ? ~last_src : req1;
                    sr_next      = sel ? data1 : data0;
                    bit_cnt_next = '0;
                    gnt0_next    = ~sel;
                    gnt1_next    = sel;
                    src_next     = sel;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_next = {1'b0, sr_reg[WIDTH-1:1]};
                if (bit_cnt_reg == CW'(WIDTH - 1)) begin
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    state_next   = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GW'(GAP - 1)) begin
                    gap_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they leave the flops aligned with the data.
        valid_next = (state_next == ST_SHIFT);
        start_next = valid_next && (bit_cnt_next == '0);
        last_next  = valid_next && (bit_cnt_next == CW'(WIDTH - 1));
        busy_next  = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
            last_src    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= sr_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            gnt0        <= gnt0_next;
            gnt1        <= gnt1_next;
            ser_valid   <= valid_next;
            frame_start <= start_next;
            frame_last  <= last_next;
            busy        <= busy_next;
            last_src    <= src_next;
        end
    end

    // Zero fill leaves the register empty outside SHIFT, so bit 0 is the serial output.
    assign ser_out = sr_reg[0];

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Randomized scoreboard bench for piso_arb_ctrl: a frame-level model predicts each
// grant (source, word, cycle) and a monitor checks every output cycle by cycle.
module tb_piso_arb_ctrl;

    localparam int W = 4;
    localparam int G = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, ser_out, ser_valid, frame_start, frame_last, busy, last_src;

    logic         rst_b = 1'b1;
    logic         req_b0 = 1'b0, req_b1 = 1'b0;
    logic [7:0]   data_b0 = 8'h81, data_b1 = 8'h00;
    logic         gnt_b0, gnt_b1, ser_out_b, ser_valid_b, frame_start_b, frame_last_b, busy_b, last_src_b;

    always #5 clk = ~clk;

    piso_arb_ctrl #(.WIDTH(W), .GAP(G)) dut (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .ser_out(ser_out), .ser_valid(ser_valid),
        .frame_start(frame_start), .frame_last(frame_last), .busy(busy), .last_src(last_src)
    );

    piso_arb_ctrl #(.WIDTH(8), .GAP(0)) dut_b (
        .clk(clk), .rst(rst_b), .req0(req_b0), .data0(data_b0), .req1(req_b1), .data1(data_b1),
        .gnt0(gnt_b0), .gnt1(gnt_b1), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
        .frame_start(frame_start_b), .frame_last(frame_last_b), .busy(busy_b), .last_src(last_src_b)
    );

    typedef struct {
        logic         src;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: the link is free again W+G edges after a grant; winner per round-robin.
    int   m_left = 0;
    logic m_last = 1'b1;
    logic m_sel;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_last = 1'b1;
            expq.delete();
        end else if (m_left > 0) begin
            m_left--;
        end else if (req0 || req1) begin
            m_sel = (req0 && req1) ? ~m_last : req1;
            expq.push_back('{m_sel, (m_sel ? data1 : data0), cyc + 1});
            m_last = m_sel;
            m_left = W + G;
        end
    end

    // Monitor: pops on every grant, then follows the frame bit by bit and the gap after it.
    int   mbit = -1;
    int   gap_left = 0;
    logic exp_last = 1'b1;
    exp_t cur;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mbit     = -1;
            gap_left = 0;
            exp_last = 1'b1;
            chk("rst_outputs", {gnt0, gnt1, ser_out, ser_valid, frame_start, frame_last, busy}, 0);
            chk("rst_last_src", last_src, 1);
        end else begin
            chk("gnt_exclusive", gnt0 & gnt1, 0);
            if (gnt0 | gnt1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt at cycle %0d: got gnt0=%0b gnt1=%0b expected none", cyc, gnt0, gnt1);
                end else begin
                    cur = expq.pop_front();
                    chk("gnt_src", gnt1, cur.src);
                    chk("gnt_cycle", cyc, cur.cyc);
                    exp_last = cur.src;
                    mbit     = 0;
                end
            end
            if (mbit >= 0) begin
                chk("ser_valid", ser_valid, 1);
                chk("ser_out", ser_out, cur.data[mbit]);
                chk("frame_start", frame_start, mbit == 0);
                chk("frame_last", frame_last, mbit == W - 1);
                chk("busy_frame", busy, 1);
                if (mbit == W - 1) begin
                    mbit     = -1;
                    gap_left = G;
                end else begin
                    mbit++;
                end
            end else begin
                chk("idle_outputs", {ser_valid, ser_out, frame_start, frame_last}, 0);
                chk("busy_gap_idle", busy, gap_left > 0);
                if (gap_left > 0) gap_left--;
            end
            chk("last_src", last_src, exp_last);
        end
    end

    // Requester behaviour: drop after grant, optionally raise a fresh random word.
    task automatic step(input bit auto_raise);
        @(negedge clk);
        if (gnt0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
        if (auto_raise) begin
            if (!req0 && $urandom_range(0, 2) != 0) begin
                req0  = 1'b1;
                data0 = W'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) != 0) begin
                req1  = 1'b1;
                data1 = W'($urandom);
            end
        end
    endtask

    int         first_b = -1;
    int         second_b = -1;
    int         nb = 0;
    logic [7:0] bits_b = '0;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        req0 = 1'b1; data0 = 4'b0111;
        repeat (10) step(0);

        req0 = 1'b1; data0 = 4'hA; req1 = 1'b1; data1 = 4'h5;
        repeat (16) step(0);

        req0 = 1'b1; data0 = 4'h9;
        repeat (3) step(0);
        req1 = 1'b1; data1 = 4'h6;
        repeat (16) step(0);

        repeat (400) step(1);
        repeat (20) step(0);

        // Reset in the middle of a frame, with a new word already pending on requester 0.
        req0 = 1'b1; data0 = 4'b1011;
        for (int i = 0; i < 20 && !frame_start; i++) step(0);
        chk("rst_test_frame_seen", frame_start, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        req0 = 1'b1; data0 = 4'b0110;
        rst  = 1'b1;
        #1;
        chk("async_rst_outputs", {gnt0, gnt1, ser_out, ser_valid, frame_start, frame_last, busy}, 0);
        chk("async_rst_last_src", last_src, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) step(0);

        chk("queue_drained", expq.size(), 0);
        chk("no_open_frame", mbit, -1);

        // WIDTH=8, GAP=0: requester held continuously, back-to-back frames.
        @(negedge clk);
        rst_b = 1'b0; req_b0 = 1'b1; data_b0 = 8'h81;
        for (int i = 0; i < 40 && second_b < 0; i++) begin
            @(negedge clk);
            if (frame_start_b) begin
                if (first_b < 0) first_b = i;
                else second_b = i;
            end
            if (ser_valid_b && first_b >= 0 && second_b < 0 && nb < 8) begin
                bits_b[nb] = ser_out_b;
                nb++;
            end
        end
        chk("w8_bits", bits_b, 8'h81);
        chk("w8_period", second_b - first_b, 9);
        req_b0 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
